// File: rtl/ram_port_arbiter.sv
// Two-requester RAM port arbiter: locks the port to one requester for a whole command sequence.
// Defining ARB_TIMEOUT_EN adds a watchdog that force-releases a stalled owner after TIMEOUT cycles.
module ram_port_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [9:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [9:0] req1_data,
  output logic       req1_ready,
  output logic       resp0_valid,
  output logic [7:0] resp0_data,
  output logic       resp1_valid,
  output logic [7:0] resp1_data,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic       timeout_err
);

  typedef enum logic [1:0] {StIdle, StLock, StWaitRd} state_e;

  localparam logic [1:0] CmdWrData = 2'b01;
  localparam logic [1:0] CmdRdData = 2'b11;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic [9:0] ram_din_q, ram_din_d;
  logic       ram_rx_valid_q, ram_rx_valid_d;
  logic       resp0_valid_q, resp0_valid_d;
  logic       resp1_valid_q, resp1_valid_d;
  logic [7:0] resp0_data_q, resp0_data_d;
  logic [7:0] resp1_data_q, resp1_data_d;
  logic       timeout_err_q, timeout_err_d;

  logic       acc0, acc1, acc, acc_id;
  logic [9:0] acc_data;
  logic [1:0] acc_cmd;
  logic       tmo;

  // Grant selection; the two readies are mutually exclusive in every state.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      StIdle: begin
        req0_ready = req0_valid && (!req1_valid || last_grant_q);
        req1_ready = req1_valid && (!req0_valid || !last_grant_q);
      end
      StLock: begin
        req0_ready = !owner_q;
        req1_ready = owner_q;
      end
      default: ;
    endcase
  end

  assign acc0     = req0_valid && req0_ready;
  assign acc1     = req1_valid && req1_ready;
  assign acc      = acc0 || acc1;
  assign acc_id   = acc1;
  assign acc_data = acc1 ? req1_data : req0_data;
  assign acc_cmd  = acc_data[9:8];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 2);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;

  // Held at zero in idle so that entry into LOCK/WAIT_RD starts a fresh count.
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    cnt_d   = '0;
    tmo     = 1'b0;
    if (state_q != StIdle && !acc) begin
      if (cnt_inc == TimeoutVal) begin
        tmo = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo            = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    ram_din_d      = ram_din_q;
    ram_rx_valid_d = 1'b0;
    resp0_valid_d  = 1'b0;
    resp1_valid_d  = 1'b0;
    resp0_data_d   = resp0_data_q;
    resp1_data_d   = resp1_data_q;
    timeout_err_d  = 1'b0;

    if (acc) begin
      ram_din_d      = acc_data;
      ram_rx_valid_d = 1'b1;
    end

    case (state_q)
      StIdle, StLock: begin
        if (acc) begin
          case (acc_cmd)
            CmdWrData: begin
              state_d      = StIdle;
              last_grant_d = acc_id;
            end
            CmdRdData: begin
              state_d = StWaitRd;
              owner_d = acc_id;
            end
            default: begin
              state_d = StLock;
              owner_d = acc_id;
            end
          endcase
        end else if (tmo) begin
          state_d       = StIdle;
          last_grant_d  = owner_q;
          timeout_err_d = 1'b1;
        end
      end
      StWaitRd: begin
        // Read data wins over a watchdog expiry in the same cycle.
        if (ram_tx_valid) begin
          state_d      = StIdle;
          last_grant_d = owner_q;
          if (owner_q) begin
            resp1_valid_d = 1'b1;
            resp1_data_d  = ram_dout;
          end else begin
            resp0_valid_d = 1'b1;
            resp0_data_d  = ram_dout;
          end
        end else if (tmo) begin
          state_d       = StIdle;
          last_grant_d  = owner_q;
          timeout_err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      owner_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      resp0_valid_q  <= 1'b0;
      resp1_valid_q  <= 1'b0;
      resp0_data_q   <= '0;
      resp1_data_q   <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      resp0_valid_q  <= resp0_valid_d;
      resp1_valid_q  <= resp1_valid_d;
      resp0_data_q   <= resp0_data_d;
      resp1_data_q   <= resp1_data_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;
  assign resp0_valid  = resp0_valid_q;
  assign resp1_valid  = resp1_valid_q;
  assign resp0_data   = resp0_data_q;
  assign resp1_data   = resp1_data_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: lock/unlock, round robin, read response, watchdog, reset.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [9:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic       resp0_valid, resp1_valid;
  logic [7:0] resp0_data, resp1_data;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout = '0;
  logic       ram_tx_valid = 1'b0;
  logic       timeout_err;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  ram_port_arbiter #(.TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .resp0_valid  (resp0_valid),
    .resp0_data   (resp0_data),
    .resp1_valid  (resp1_valid),
    .resp1_data   (resp1_data),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Registered outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_din"}, ram_din, 10'h000);
    check({tag, "_rxv"}, ram_rx_valid, 1'b0);
    check({tag, "_resp"}, {resp0_valid, resp1_valid, timeout_err}, 3'b000);
    check({tag, "_rdata"}, {resp0_data, resp1_data}, 16'h0000);
  endtask

  initial begin
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Req0 write sequence, req1 blocked while locked.
    req0_valid = 1'b1; req0_data = 10'h005; #1;
    check("a_rdy", {req0_ready, req1_ready}, 2'b10);
    tick();
    check("a_beat0", {ram_rx_valid, ram_din}, {1'b1, 10'h005});
    req0_data = 10'h1AA; req1_valid = 1'b1; req1_data = 10'h0F0; #1;
    check("a_lock_rdy", {req0_ready, req1_ready}, 2'b10);
    tick();
    check("a_beat1", {ram_rx_valid, ram_din}, {1'b1, 10'h1AA});
    req0_valid = 1'b0; #1;
    check("a_idle_rdy", {req0_ready, req1_ready}, 2'b01);
    req1_valid = 1'b0;
    tick();
    check("a_hold", {ram_rx_valid, ram_din}, {1'b0, 10'h1AA});

    // Tie after reset goes to req0, then req1; req1 issues a read.
    rst_n = 1'b0; #1;
    check_reset_outputs("rst_async");
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 10'h000;
    req1_valid = 1'b1; req1_data = 10'h210; #1;
    check("b_tie0", {req0_ready, req1_ready}, 2'b10);
    tick();
    check("b_beat0", ram_din, 10'h000);
    req0_data = 10'h133; #1;
    check("b_lock_rdy", {req0_ready, req1_ready}, 2'b10);
    tick();
    check("b_beat1", ram_din, 10'h133);
    req0_data = 10'h044; #1;
    check("b_tie1", {req0_ready, req1_ready}, 2'b01);
    tick();
    check("b_beat2", {ram_rx_valid, ram_din}, {1'b1, 10'h210});
    req1_data = 10'h300; #1;
    check("b_lock1_rdy", {req0_ready, req1_ready}, 2'b01);
    tick();
    check("b_beat3", ram_din, 10'h300);
    req1_valid = 1'b0; #1;
    check("b_wait_rdy", {req0_ready, req1_ready}, 2'b00);
    ram_tx_valid = 1'b1; ram_dout = 8'h5C;
    tick();
    ram_tx_valid = 1'b0;
    check("b_resp1", {resp1_valid, resp1_data}, {1'b1, 8'h5C});
    check("b_resp0", resp0_valid, 1'b0);
    check("b_no_rx", ram_rx_valid, 1'b0);
    check("b_idle_rdy", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 1'b0;
    tick();
    check("b_resp_once", {resp0_valid, resp1_valid}, 2'b00);

    // Stray RAM strobe in idle.
    ram_tx_valid = 1'b1; ram_dout = 8'hA5;
    tick();
    ram_tx_valid = 1'b0;
    check("c_stray", {resp0_valid, resp1_valid}, 2'b00);

    // Req0 locks and goes silent while req1 waits.
    req0_valid = 1'b1; req0_data = 10'h010;
    tick();
    check("d_beat", ram_din, 10'h010);
    req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 10'h0AA;
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < 15; i++) begin
      tick();
      check("d_tmo_hold", {req1_ready, timeout_err}, 2'b00);
    end
    tick();
    check("d_tmo_err", timeout_err, 1'b1);
    check("d_tmo_grant", req1_ready, 1'b1);
    tick();
    check("d_tmo_once", timeout_err, 1'b0);
    check("d_req1_beat", ram_din, 10'h0AA);
`else
    for (int i = 0; i < 30; i++) tick();
    check("d_lock_held", req1_ready, 1'b0);
    check("d_no_tmo", timeout_err, 1'b0);
    req0_valid = 1'b1; req0_data = 10'h1BB; #1;
    check("d_owner_rdy", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    check("d_close", ram_din, 10'h1BB);
    #1;
    check("d_req1_grant", req1_ready, 1'b1);
    tick();
    check("d_req1_beat", ram_din, 10'h0AA);
`endif
    req1_data = 10'h1CC;
    tick();
    req1_valid = 1'b0;
    check("d_req1_close", ram_din, 10'h1CC);

    // Reset while waiting for read data discards the response.
    req0_valid = 1'b1; req0_data = 10'h300;
    tick();
    req0_data = 10'h000; #1;
    check("e_wait_rdy", {req0_ready, req1_ready}, 2'b00);
    req0_valid = 1'b0;
    rst_n = 1'b0; #1;
    check("e_rst_async", ram_din, 10'h000);
    tick();
    rst_n = 1'b1;
    ram_tx_valid = 1'b1; ram_dout = 8'h77;
    tick();
    ram_tx_valid = 1'b0;
    check_reset_outputs("e_post");
    req0_valid = 1'b1; req0_data = 10'h044; #1;
    check("e_idle_rdy", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: idle-cycle limit for a locked or read-wait owner; used only when ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid, req1_valid  input  1  requester n presents a 10-bit RAM command beat.
REQ-005 req0_data, req1_data  input  10  command beat; bits [9:8] are cmd: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
REQ-006 req0_ready, req1_ready  output  1  combinational; a beat is accepted when valid and ready are both high.
REQ-007 resp0_valid, resp1_valid  output  1  one-cycle pulse delivering read data to the issuing requester.
REQ-008 resp0_data, resp1_data  output  8  read data, valid only while the matching resp_valid is high.
REQ-009 ram_din  output  10  beat forwarded to the RAM.
REQ-010 ram_rx_valid  output  1  one-cycle strobe qualifying ram_din.
REQ-011 ram_dout  input  8  RAM read data.
REQ-012 ram_tx_valid  input  1  RAM read-data strobe.
REQ-013 timeout_err  output  1  one-cycle pulse when a lock is forcibly released.

Function
REQ-014 The FSM SHALL have states IDLE, LOCK and WAIT_RD, plus a 1-bit owner register and a 1-bit last_grant register.
REQ-015 In IDLE, reqn_ready SHALL be high for the selected requester only: the sole valid requester, or when both are valid, the one not equal to last_grant.
REQ-016 In LOCK, only the owner's ready SHALL be high; in WAIT_RD, both readies SHALL be low.
REQ-017 An accepted beat SHALL appear on ram_din with ram_rx_valid high for exactly one cycle, on the cycle after acceptance (latency 1); ram_din holds its value otherwise.
REQ-018 Transitions on an accepted beat: cmd 00/10 -> LOCK (owner = acceptor); cmd 01 -> IDLE; cmd 11 -> WAIT_RD (owner = acceptor).
REQ-019 When the FSM enters IDLE from LOCK or WAIT_RD, or on a cmd-01 beat accepted in IDLE, last_grant SHALL be set to the acceptor.
REQ-020 In LOCK, a further cmd 00/10 beat from the owner SHALL keep LOCK (re-address).
REQ-021 In WAIT_RD, ram_tx_valid SHALL cause the owner's resp_data = ram_dout and resp_valid high on the next cycle for one cycle, and a transition to IDLE.
REQ-022 ram_tx_valid outside WAIT_RD SHALL be ignored, with no resp_valid.
REQ-023 Requester data SHALL never be interleaved: between a cmd 00/10 beat and the closing 01/11 beat, no other requester's beat reaches the RAM.

Reset
REQ-024 While rst_n is low: state = IDLE, owner = 0, last_grant = 1 (requester 0 wins the first tie), ram_din = 0, ram_rx_valid = 0, resp*_valid = 0, resp*_data = 0, timeout_err = 0, timeout counter = 0.
REQ-025 Reset asserted mid-transaction SHALL discard the lock and any pending read response.

Configuration
REQ-026 With macro ARB_TIMEOUT_EN defined, a counter SHALL clear on every owner-accepted beat and on entry to LOCK or WAIT_RD, and SHALL increment each cycle in LOCK or WAIT_RD.
REQ-027 With ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT, the FSM SHALL go to IDLE, pulse timeout_err for one cycle, set last_grant = owner and emit no resp_valid.
REQ-028 Without ARB_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied to 0, and LOCK and WAIT_RD SHALL be held indefinitely.

Verification
REQ-029 Req0 sends 0x005 then 0x1AA -> ram_din is 0x005 then 0x1AA, each with a one-cycle ram_rx_valid; req1 ready stays low in between; the FSM ends in IDLE.
REQ-030 Both requesters valid after reset -> req0 is granted first; after its transaction closes, req1 is granted (round robin).
REQ-031 Req1 sends 0x210 then 0x300, and the RAM returns ram_tx_valid with ram_dout = 0x5C -> resp1_valid pulses once with resp1_data = 0x5C; resp0_valid stays 0.
REQ-032 Req0 sends 0x010 and then goes silent, with ARB_TIMEOUT_EN defined and TIMEOUT = 15 -> after 15 cycles in LOCK, timeout_err pulses and req1 is granted; without the macro, the FSM stays in LOCK.
REQ-033 rst_n is pulsed low while in WAIT_RD, then ram_tx_valid arrives -> no resp_valid; all outputs are at their REQ-024 reset values.
